perceptron_trainer: RTL
=======================

# perceptron_trainer

Training sequencer that drives a single perceptron instance as its initiator. It stores a small labelled dataset and, on `start`, clears the perceptron. It then presents every sample per epoch, asserts the perceptron's training strobe on mispredicted samples, and counts errors per epoch. It stops on an error-free epoch or at an epoch limit, and sits beside the perceptron in the standalone perceptron top level.

## Interface
- `input_units`, default 2: features per sample; must match the driven perceptron.
- `depth`, default 8: maximum stored samples.
- `max_epochs`, default 64: epoch limit, ≥1.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high; clears all control state and outputs.
- `load_en`, input, 1: write a sample to memory; ignored while `busy`.
- `load_addr`, input, $clog2(depth): sample write address.
- `load_values`, input, sfp[input_units]: sample features.
- `load_expected`, input, sfp: sample label, 0 or ONE.
- `num_samples`, input, $clog2(depth+1): active samples 0..depth; sampled on `start`.
- `start`, input, 1: begin a run; ignored while `busy`.
- `lr_in`, input, sfp: learning rate; sampled on `start`.
- `prediction`, input, sfp: perceptron output, combinational on the perceptron side.
- `perc_rst`, output, 1: synchronous clear to the perceptron.
- `values`, output, sfp[input_units]: features to the perceptron.
- `expected`, output, sfp: label to the perceptron.
- `training`, output, 1: perceptron update strobe.
- `learning_rate`, output, sfp: latched `lr_in`.
- `busy`, output, 1: run in progress.
- `done`, output, 1: one-cycle pulse when a run ends.
- `converged`, output, 1: last run ended with an error-free epoch.
- `epoch`, output, $clog2(max_epochs+1): epochs completed in the current or last run.
- `epoch_errors`, output, $clog2(depth+1): mismatches in the last completed epoch.

## Operation
- The FSM has six states: IDLE, CLEAR, PRESENT, TRAIN, EPOCH_END, DONE. All outputs are registered or decoded from state (Moore).
- **IDLE → CLEAR** on `start`. This latches `num_samples` and `lr_in`, and clears `epoch`, the index, the error count and `converged`.
- **CLEAR**:
  - `perc_rst`=1 for exactly one cycle.
  - Next state is PRESENT, or DONE if `num_samples`=0. The zero-sample case ends with `converged`=1, `epoch`=0.
- **PRESENT**:
  - Drive `values`/`expected` from mem[idx], with `training`=0.
  - Register `mismatch` = (`prediction` != `expected`); the error count increments if set.
  - Next state is TRAIN.
- **TRAIN**:
  - Hold the same `values`/`expected`; `training` = `mismatch`.
  - idx increments. Next state is EPOCH_END if idx was `num_samples`-1, else PRESENT.
- **EPOCH_END**:
  - `epoch` increments and `epoch_errors` takes the error count.
  - Count 0 → DONE with `converged`=1.
  - Otherwise, if the incremented `epoch` = `max_epochs` → DONE with `converged`=0.
  - Otherwise clear the count, set idx=0, and go to PRESENT.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `converged`, `epoch` and `epoch_errors` hold until the next accepted `start`.
- The sample memory is not reset. Writes land at the clock edge, and `load_addr` ≥ `depth` is ignored.
- Label compare is an exact sfp equality. Counters saturate by construction, so no wrap is possible.

## Timing
- Reset values: `perc_rst`=0, `values`=0, `expected`=0, `training`=0, `learning_rate`=0, `busy`=0, `done`=0, `converged`=0, `epoch`=0, `epoch_errors`=0. State is IDLE.
- `busy`=1 from the cycle after `start` through DONE inclusive.
- Per sample: 2 cycles. Per epoch: 2·N+1 cycles.
- `done` asserts 1 + E·(2·N+1) cycles after the CLEAR cycle begins.
- `start` and `load_en` in the same IDLE cycle: the write completes, and the run reads the new data.
- `rst` mid-run: immediate return to IDLE with all outputs at reset values. No `done` pulse is generated.

## Structure
- Uses `sfp`, `ONE` and sfp equality from the `FixedPoint` package. The trainer adds no new package contents.
- A state enum is local to the module.
- Optional sub-module `sample_mem`: depth×(input_units+1) sfp register file with one write port and one asynchronous read port.

## Test plan
- **AND dataset**: samples {0,0}→0, {0,ONE}→0, {ONE,0}→0, {ONE,ONE}→ONE; N=4, lr=ONE, perceptron attached.
  - Required: `done` with `converged`=1, `epoch_errors`=0, `epoch` ≤ 8.
  - Required: cycle count equals 1+`epoch`·9.
- **XOR dataset**, `max_epochs`=5 → `done` at cycle 1+5·9=46, `converged`=0, `epoch`=5, `epoch_errors` > 0.
- **`num_samples`=0** → `perc_rst` pulse, `done` 2 cycles after `start`, `converged`=1, `epoch`=0, `training` never asserted.
- **Assert `rst` in epoch 2** → all outputs 0 at once, no `done`. A later `start` reruns AND correctly from a cleared perceptron.
- **`start` and `load_en` while `busy`** → both ignored: memory unchanged, run timing unchanged.
- **Preset a perceptron so sample 1 mispredicts** → `training`=1 only in TRAIN of sample 1, exactly one cycle, with `values` stable across PRESENT and TRAIN.

Source files
------------

// File: rtl/perceptron_trainer_pkg.sv
// Fixed-point types shared by the perceptron and its training sequencer.
// sfp is signed Q8.8; ONE is the label value for the positive class.
package perceptron_trainer_pkg;

  localparam int unsigned FracBits = 8;

  typedef logic signed [15:0] sfp;

  localparam sfp ONE = sfp'(1 << FracBits);

  function automatic logic sfp_eq(input sfp a, input sfp b);
    return a == b;
  endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// Trainer-to-perceptron bus: the trainer drives samples and the update strobe,
// the perceptron returns its combinational prediction.
interface perceptron_trainer_if #(
  parameter int unsigned input_units = 2
);
  import perceptron_trainer_pkg::*;

  logic perc_rst;
  sfp   values [input_units];
  sfp   expected;
  logic training;
  sfp   learning_rate;
  sfp   prediction;

  modport master (
    output perc_rst, values, expected, training, learning_rate,
    input  prediction
  );

  modport slave (
    input  perc_rst, values, expected, training, learning_rate,
    output prediction
  );

endinterface

// File: rtl/perceptron_trainer_sample_mem.sv
// Labelled sample store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module perceptron_trainer_sample_mem
  import perceptron_trainer_pkg::*;
#(
  parameter int unsigned input_units = 2,
  parameter int unsigned depth       = 8,
  localparam int unsigned AddrW      = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  sfp               wr_values [input_units],
  input  sfp               wr_label,
  input  logic [AddrW-1:0] rd_addr,
  output sfp               rd_values [input_units],
  output sfp               rd_label
);

  sfp feat_q  [depth][input_units];
  sfp label_q [depth];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < depth)) begin
      feat_q[wr_addr]  <= wr_values;
      label_q[wr_addr] <= wr_label;
    end
  end

  always_comb begin
    rd_values = feat_q[rd_addr];
    rd_label  = label_q[rd_addr];
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Training sequencer: clears the attached perceptron, presents every stored sample
// per epoch, strobes an update on mispredictions and stops on convergence or limit.
module perceptron_trainer
  import perceptron_trainer_pkg::*;
#(
  parameter int unsigned input_units = 2,
  parameter int unsigned depth       = 8,
  parameter int unsigned max_epochs  = 64,
  localparam int unsigned AddrW      = (depth > 1) ? $clog2(depth) : 1,
  localparam int unsigned CntW       = $clog2(depth + 1),
  localparam int unsigned EpW        = $clog2(max_epochs + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [AddrW-1:0]      load_addr,
  input  sfp                    load_values [input_units],
  input  sfp                    load_expected,
  input  logic [CntW-1:0]       num_samples,
  input  logic                  start,
  input  sfp                    lr_in,
  perceptron_trainer_if.master  perc,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic [EpW-1:0]        epoch,
  output logic [CntW-1:0]       epoch_errors
);

  typedef enum logic [2:0] {
    StIdle, StClear, StPresent, StTrain, StEpochEnd, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] idx_q, idx_d;
  logic [CntW-1:0]  num_q, num_d;
  logic [CntW-1:0]  err_q, err_d;
  logic [CntW-1:0]  eerr_q, eerr_d;
  logic [EpW-1:0]   epoch_q, epoch_d;
  logic             mismatch_q, mismatch_d;
  logic             conv_q, conv_d;
  sfp               lr_q, lr_d;

  sfp   rd_values [input_units];
  sfp   rd_label;
  logic presenting;

  perceptron_trainer_sample_mem #(
    .input_units (input_units),
    .depth       (depth)
  ) u_sample_mem (
    .clk       (clk),
    .wr_en     (load_en && !busy),
    .wr_addr   (load_addr),
    .wr_values (load_values),
    .wr_label  (load_expected),
    .rd_addr   (idx_q),
    .rd_values (rd_values),
    .rd_label  (rd_label)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    num_d      = num_q;
    err_d      = err_q;
    eerr_d     = eerr_q;
    epoch_d    = epoch_q;
    mismatch_d = mismatch_q;
    conv_d     = conv_q;
    lr_d       = lr_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          num_d   = num_samples;
          lr_d    = lr_in;
          epoch_d = '0;
          idx_d   = '0;
          err_d   = '0;
          conv_d  = 1'b0;
        end
      end
      StClear: begin
        if (num_q == '0) begin
          state_d = StDone;
          conv_d  = 1'b1;
        end else begin
          state_d = StPresent;
        end
      end
      StPresent: begin
        mismatch_d = !sfp_eq(perc.prediction, rd_label);
        if (mismatch_d) err_d = err_q + CntW'(1);
        state_d = StTrain;
      end
      StTrain: begin
        idx_d = idx_q + AddrW'(1);
        if (CntW'(idx_q) == num_q - CntW'(1)) state_d = StEpochEnd;
        else                                  state_d = StPresent;
      end
      StEpochEnd: begin
        epoch_d = epoch_q + EpW'(1);
        eerr_d  = err_q;
        if (err_q == '0) begin
          state_d = StDone;
          conv_d  = 1'b1;
        end else if (epoch_d == EpW'(max_epochs)) begin
          state_d = StDone;
        end else begin
          err_d   = '0;
          idx_d   = '0;
          state_d = StPresent;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      num_q      <= '0;
      err_q      <= '0;
      eerr_q     <= '0;
      epoch_q    <= '0;
      mismatch_q <= 1'b0;
      conv_q     <= 1'b0;
      lr_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      err_q      <= err_d;
      eerr_q     <= eerr_d;
      epoch_q    <= epoch_d;
      mismatch_q <= mismatch_d;
      conv_q     <= conv_d;
      lr_q       <= lr_d;
    end
  end

  // Sample bus is zero outside PRESENT/TRAIN so a reset never exposes memory contents.
  always_comb begin
    presenting         = (state_q == StPresent) || (state_q == StTrain);
    perc.perc_rst      = (state_q == StClear);
    perc.training      = (state_q == StTrain) && mismatch_q;
    perc.expected      = presenting ? rd_label : '0;
    perc.learning_rate = lr_q;
    for (int unsigned i = 0; i < input_units; i++) begin
      perc.values[i] = presenting ? rd_values[i] : '0;
    end
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    converged    = conv_q;
    epoch        = epoch_q;
    epoch_errors = eerr_q;
  end

endmodule
